// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, ALU intent and write-back source encodings.
// Imported by the decode, ALU-control and datapath blocks.
package riscv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        RTY = 2'b10,
        ITY = 2'b11
    } alu_intent_t;

    // 2'b11 is reserved and never produced by the decoder.
    typedef enum logic [1:0] {
        ALU = 2'b00,
        PC4 = 2'b01,
        MEM = 2'b10
    } rd_src_t;

    typedef struct packed {
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        mem_write_en;
        logic        mem_read_en;
        logic        reg_write_en;
        rd_src_t     rd_src;
        alu_intent_t alu_intent;
        logic        alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        is_branch:    1'b0,
        is_jal:       1'b0,
        is_jalr:      1'b0,
        mem_write_en: 1'b0,
        mem_read_en:  1'b0,
        reg_write_en: 1'b0,
        rd_src:       ALU,
        alu_intent:   ADD,
        alu_src:      1'b0
    };

endpackage

// File: rtl/control_unit.sv
// ID-stage main decoder: opcode -> datapath control bundle, plus a sticky illegal-opcode monitor.
// Monitor present only when CONTROL_UNIT_ILLEGAL_MON_EN is defined.
module control_unit
    import riscv_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       valid_i,
    output logic       is_branch,
    output logic       is_jal,
    output logic       is_jalr,
    output logic       mem_write_en,
    output logic       mem_read_en,
    output logic       reg_write_en,
    output logic [1:0] rd_src_optn,
    output logic [1:0] alu_intent,
    output logic       alu_src_optn,
    output logic       illegal_o,
    output logic       illegal_seen_o
);

    ctrl_t ctrl;
    logic  illegal_dec;

    // X/Z opcodes match no item and fall into the illegal default.
    always_comb begin
        ctrl        = CTRL_NONE;
        illegal_dec = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.alu_intent   = RTY;
            end
            OP_ITYPE: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.alu_intent   = ITY;
                ctrl.alu_src      = 1'b1;
            end
            OP_LOAD: begin
                ctrl.mem_read_en  = 1'b1;
                ctrl.reg_write_en = 1'b1;
                ctrl.rd_src       = MEM;
                ctrl.alu_src      = 1'b1;
            end
            OP_STORE: begin
                ctrl.mem_write_en = 1'b1;
                ctrl.alu_src      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.is_branch  = 1'b1;
                ctrl.alu_intent = SUB;
            end
            OP_JAL: begin
                ctrl.is_jal       = 1'b1;
                ctrl.reg_write_en = 1'b1;
                ctrl.rd_src       = PC4;
            end
            OP_JALR: begin
                ctrl.is_jalr      = 1'b1;
                ctrl.reg_write_en = 1'b1;
                ctrl.rd_src       = PC4;
                ctrl.alu_src      = 1'b1;
            end
            // Operand A is zeroed in the datapath, so ADD yields the immediate.
            OP_LUI: begin
                ctrl.reg_write_en = 1'b1;
                ctrl.alu_src      = 1'b1;
            end
            default: begin
                ctrl        = CTRL_NONE;
                illegal_dec = 1'b1;
            end
        endcase
    end

    assign is_branch    = ctrl.is_branch;
    assign is_jal       = ctrl.is_jal;
    assign is_jalr      = ctrl.is_jalr;
    assign mem_write_en = ctrl.mem_write_en;
    assign mem_read_en  = ctrl.mem_read_en;
    assign reg_write_en = ctrl.reg_write_en;
    assign rd_src_optn  = ctrl.rd_src;
    assign alu_intent   = ctrl.alu_intent;
    assign alu_src_optn = ctrl.alu_src;

`ifdef CONTROL_UNIT_ILLEGAL_MON_EN
    logic illegal_seen_q;
    logic illegal_seen_d;

    always_comb begin
        illegal_seen_d = illegal_seen_q | (valid_i & illegal_dec);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            illegal_seen_q <= 1'b0;
        end else begin
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign illegal_o      = illegal_dec;
    assign illegal_seen_o = illegal_seen_q;
`else
    logic unused_mon_sigs;
    assign unused_mon_sigs = ^{clk_i, rst_i, valid_i, illegal_dec};

    assign illegal_o      = 1'b0;
    assign illegal_seen_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: legal decode rows, illegal opcodes, monitor and 128-opcode sweep.
// Expectations follow CONTROL_UNIT_ILLEGAL_MON_EN when it is defined for the build.
module tb_control_unit;

`ifdef CONTROL_UNIT_ILLEGAL_MON_EN
    localparam logic MON = 1'b1;
`else
    localparam logic MON = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [6:0] opcode_i = 7'b0;
    logic       valid_i = 1'b0;
    logic       is_branch, is_jal, is_jalr, mem_write_en, mem_read_en, reg_write_en;
    logic [1:0] rd_src_optn, alu_intent;
    logic       alu_src_optn, illegal_o, illegal_seen_o;

    int tests = 0;
    int fails = 0;

    control_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .opcode_i       (opcode_i),
        .valid_i        (valid_i),
        .is_branch      (is_branch),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .reg_write_en   (reg_write_en),
        .rd_src_optn    (rd_src_optn),
        .alu_intent     (alu_intent),
        .alu_src_optn   (alu_src_optn),
        .illegal_o      (illegal_o),
        .illegal_seen_o (illegal_seen_o)
    );

    always #5 clk_i = ~clk_i;

    // Packed as {br,jal,jalr,mw,mr,rw,rsrc[1:0],aint[1:0],asrc}.
    logic [11:0] ctrl_vec;
    assign ctrl_vec = {is_branch, is_jal, is_jalr, mem_write_en, mem_read_en, reg_write_en,
                       rd_src_optn, alu_intent, alu_src_optn};

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [6:0] op, input logic [11:0] exp_ctrl,
                          input logic exp_ill);
        opcode_i = op;
        #1;
        chk({tag, "_ctrl"}, ctrl_vec, exp_ctrl);
        chk({tag, "_illegal"}, {11'b0, illegal_o}, {11'b0, exp_ill});
    endtask

    int n_active;
    int n_legal;

    initial begin
        // Legal decode rows
        chk_op("rtype",  7'b0110011, 12'b000001_00_10_0, 1'b0);
        chk_op("itype",  7'b0010011, 12'b000001_00_11_1, 1'b0);
        chk_op("load",   7'b0000011, 12'b000011_10_00_1, 1'b0);
        chk_op("store",  7'b0100011, 12'b000100_00_00_1, 1'b0);
        chk_op("branch", 7'b1100011, 12'b100000_00_01_0, 1'b0);
        chk_op("jal",    7'b1101111, 12'b010001_01_00_0, 1'b0);
        chk_op("jalr",   7'b1100111, 12'b001001_01_00_1, 1'b0);
        chk_op("lui",    7'b0110111, 12'b000001_00_00_1, 1'b0);

        // Illegal opcodes
        chk_op("op7f",   7'b1111111, 12'b0, MON);
        chk_op("auipc",  7'b0010111, 12'b0, MON);
        chk_op("fence",  7'b0001111, 12'b0, MON);
        chk_op("system", 7'b1110011, 12'b0, MON);
        chk_op("lo_bits", 7'b0110010, 12'b0, MON);

        // Monitor: reset, valid-gated set, sticky hold
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        chk("seen_in_reset", {11'b0, illegal_seen_o}, 12'b0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        opcode_i = 7'b1111111;
        valid_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk("seen_valid_low", {11'b0, illegal_seen_o}, 12'b0);
        end
        @(negedge clk_i);
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("seen_set", {11'b0, illegal_seen_o}, {11'b0, MON});
        @(negedge clk_i);
        valid_i  = 1'b0;
        opcode_i = 7'b0110011;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            chk("seen_hold", {11'b0, illegal_seen_o}, {11'b0, MON});
        end
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("seen_hold_legal", {11'b0, illegal_seen_o}, {11'b0, MON});

        // Asynchronous clear between edges, then reset beats an illegal decode
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("seen_async_clr", {11'b0, illegal_seen_o}, 12'b0);
        opcode_i = 7'b1111111;
        valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        chk("seen_rst_wins", {11'b0, illegal_seen_o}, 12'b0);
        @(negedge clk_i);
        rst_i   = 1'b0;
        valid_i = 1'b0;

        // Sweep all opcodes for structural invariants
        n_active = 0;
        n_legal  = 0;
        for (int i = 0; i < 128; i++) begin
            opcode_i = 7'(i);
            #1;
            chk("onehot_jump", {11'b0, (32'(is_branch) + 32'(is_jal) + 32'(is_jalr)) > 1},
                12'b0);
            chk("rd_wr_excl", {11'b0, mem_read_en & mem_write_en}, 12'b0);
            chk("rsrc_rsvd", {11'b0, rd_src_optn == 2'b11}, 12'b0);
            if (ctrl_vec != 12'b0) n_active++;
            if (!illegal_o) n_legal++;
        end
        chk("sweep_active", 12'(n_active), 12'd8);
        chk("sweep_legal", 12'(n_legal), MON ? 12'd8 : 12'd128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
